// File: rtl/cc_io_hub_if.sv
// rtl/cc_io_hub_if.sv - PicoBlaze port-I/O bus between the processor and the hub
interface cc_io_hub_if;
    logic [7:0] port_id;
    logic [7:0] port_out;
    logic [7:0] port_in;
    logic       write_strobe;
    logic       kwrite_strobe;
    logic       read_strobe;
    logic       interrupt;
    logic       interrupt_ack;

    modport master (
        output port_id, port_out, write_strobe, kwrite_strobe, read_strobe, interrupt_ack,
        input  port_in, interrupt
    );

    modport slave (
        input  port_id, port_out, write_strobe, kwrite_strobe, read_strobe, interrupt_ack,
        output port_in, interrupt
    );
endinterface

// File: rtl/cc_io_hub.sv
// rtl/cc_io_hub.sv - PicoBlaze port-I/O hub for LogCap, UART FIFOs and board IO
// Optional button edge events at port 0x17 when CCH_BUTTON_EVENT_EN is defined.
module cc_io_hub #(
    parameter int NUM_REGS   = 8,
    parameter int INT_PERIOD = 100_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    cc_io_hub_if.slave            pb,
    input  logic [7:0]            data_rx,
    input  logic                  urx_buffer_full,
    input  logic                  urx_buffer_half_full,
    input  logic                  urx_buffer_data_present,
    output logic                  urx_buffer_read,
    output logic [7:0]            data_tx,
    input  logic                  utx_buffer_full,
    input  logic                  utx_buffer_half_full,
    input  logic                  utx_buffer_data_present,
    output logic                  utx_buffer_write,
    input  logic [8*NUM_REGS-1:0] reg_in,
    output logic [8*NUM_REGS-1:0] reg_out,
    output logic [7:0]            command,
    output logic                  command_strobe,
    input  logic [7:0]            status,
    output logic [15:0]           led,
    input  logic [15:0]           switch,
    input  logic [7:0]            button
);
    localparam int CNT_W = $clog2(INT_PERIOD);

    typedef enum logic {S_IDLE, S_PEND} int_state_e;

    int_state_e            state_q;
    logic                  interrupt_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  tick;
    logic [7:0]            port_in_q, port_in_d;
    logic [8*NUM_REGS-1:0] reg_out_q, reg_out_d;
    logic [7:0]            command_q, command_d;
    logic                  command_strobe_q, command_strobe_d;
    logic [15:0]           led_q, led_d;
    logic                  int_en_q, int_en_d;
    logic [2:0]            flags_q, flags_d;   // {tx_ovf, rx_udf, int_ovr}
    logic                  urx_read_q, urx_read_d;
    logic                  wr_cmd, wr_tx, rd_rx, int_ovr_set;

    assign tick   = (cnt_q == CNT_W'(INT_PERIOD - 1));
    assign cnt_d  = tick ? '0 : cnt_q + 1'b1;
    assign wr_cmd = pb.write_strobe && (pb.port_id == 8'h10);
    assign wr_tx  = pb.write_strobe && (pb.port_id == 8'h11);
    assign rd_rx  = pb.read_strobe && (pb.port_id == 8'h11);

`ifdef CCH_BUTTON_EVENT_EN
    logic [7:0] btn_q, btn_evt_q, btn_evt_d;
    logic       rd_evt;

    assign rd_evt    = pb.read_strobe && (pb.port_id == 8'h17);
    // A fresh edge in the clearing cycle survives the clear
    assign btn_evt_d = (rd_evt ? 8'h00 : btn_evt_q) | (button & ~btn_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q     <= '0;
            btn_evt_q <= '0;
        end else begin
            btn_q     <= button;
            btn_evt_q <= btn_evt_d;
        end
    end
`endif

    always_comb begin
        reg_out_d = reg_out_q;
        if (pb.kwrite_strobe) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (pb.port_id[3:0] == 4'(i)) reg_out_d[8*i +: 8] = pb.port_out;
        end
        if (pb.write_strobe) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (pb.port_id == 8'(i)) reg_out_d[8*i +: 8] = pb.port_out;
        end
    end

    always_comb begin
        command_d        = wr_cmd ? pb.port_out : command_q;
        command_strobe_d = wr_cmd;
        led_d            = led_q;
        int_en_d         = int_en_q;
        flags_d          = flags_q;
        if (pb.write_strobe && pb.port_id == 8'h12) led_d[7:0]  = pb.port_out;
        if (pb.write_strobe && pb.port_id == 8'h13) led_d[15:8] = pb.port_out;
        if (pb.write_strobe && pb.port_id == 8'h14) int_en_d    = pb.port_out[0];
        if (pb.write_strobe && pb.port_id == 8'h15) flags_d     = flags_q & ~pb.port_out[2:0];
        // Set events are applied after the clear so they win a same-cycle race
        flags_d    = flags_d | {wr_tx & utx_buffer_full, rd_rx & ~urx_buffer_data_present, int_ovr_set};
        urx_read_d = rd_rx & urx_buffer_data_present;
    end

    assign int_ovr_set = (state_q == S_PEND) && int_en_d && tick && !pb.interrupt_ack;

    always_comb begin
        port_in_d = 8'h00;
        for (int i = 0; i < NUM_REGS; i++)
            if (pb.port_id == 8'(i)) port_in_d = reg_in[8*i +: 8];
        case (pb.port_id)
            8'h10: port_in_d = status;
            8'h11: port_in_d = data_rx;
            8'h12: port_in_d = {2'b00, urx_buffer_full, urx_buffer_half_full, urx_buffer_data_present,
                                utx_buffer_full, utx_buffer_half_full, utx_buffer_data_present};
            8'h13: port_in_d = switch[7:0];
            8'h14: port_in_d = switch[15:8];
            8'h15: port_in_d = button;
            8'h16: port_in_d = {5'b00000, flags_q};
`ifdef CCH_BUTTON_EVENT_EN
            8'h17: port_in_d = btn_evt_q;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q            <= '0;
            port_in_q        <= '0;
            reg_out_q        <= '0;
            command_q        <= '0;
            command_strobe_q <= 1'b0;
            led_q            <= '0;
            int_en_q         <= 1'b1;
            flags_q          <= '0;
            urx_read_q       <= 1'b0;
        end else begin
            cnt_q            <= cnt_d;
            port_in_q        <= port_in_d;
            reg_out_q        <= reg_out_d;
            command_q        <= command_d;
            command_strobe_q <= command_strobe_d;
            led_q            <= led_d;
            int_en_q         <= int_en_d;
            flags_q          <= flags_d;
            urx_read_q       <= urx_read_d;
        end
    end

    // An ack coinciding with a tick re-arms immediately, so the request stays pending
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            interrupt_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (tick && int_en_d) begin
                    state_q     <= S_PEND;
                    interrupt_q <= 1'b1;
                end
                S_PEND: if (!int_en_d || (pb.interrupt_ack && !tick)) begin
                    state_q     <= S_IDLE;
                    interrupt_q <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    interrupt_q <= 1'b0;
                end
            endcase
        end
    end

    assign pb.port_in       = port_in_q;
    assign pb.interrupt     = interrupt_q;
    assign urx_buffer_read  = urx_read_q;
    assign data_tx          = pb.port_out;
    assign utx_buffer_write = wr_tx;
    assign reg_out          = reg_out_q;
    assign command          = command_q;
    assign command_strobe   = command_strobe_q;
    assign led              = led_q;
endmodule

// File: tb/tb_cc_io_hub.sv
// tb/tb_cc_io_hub.sv - self-checking bench for cc_io_hub against a behavioural port-map model
module tb_cc_io_hub;
    localparam int NR = 8;
    localparam int IP = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    data_rx;
    logic          urx_full, urx_half, urx_pres, urx_read;
    logic [7:0]    data_tx;
    logic          utx_full, utx_half, utx_pres, utx_write;
    logic [8*NR-1:0] reg_in, reg_out;
    logic [7:0]    command, status, button;
    logic          cmd_strobe;
    logic [15:0]   led, switch;

    always #5 clk = ~clk;

    cc_io_hub_if pb();

    cc_io_hub #(.NUM_REGS(NR), .INT_PERIOD(IP)) dut (
        .clk(clk), .reset(reset), .pb(pb),
        .data_rx(data_rx), .urx_buffer_full(urx_full), .urx_buffer_half_full(urx_half),
        .urx_buffer_data_present(urx_pres), .urx_buffer_read(urx_read),
        .data_tx(data_tx), .utx_buffer_full(utx_full), .utx_buffer_half_full(utx_half),
        .utx_buffer_data_present(utx_pres), .utx_buffer_write(utx_write),
        .reg_in(reg_in), .reg_out(reg_out), .command(command), .command_strobe(cmd_strobe),
        .status(status), .led(led), .switch(switch), .button(button)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0]  m_reg [NR];
    logic [7:0]  m_cmd;
    logic [15:0] m_led;
    logic        m_int_en;
    logic [2:0]  m_flags;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8*NR-1:0] m_pack();
        logic [8*NR-1:0] v;
        for (int i = 0; i < NR; i++) v[8*i +: 8] = m_reg[i];
        return v;
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] a);
        if (a < NR) return reg_in[8*int'(a) +: 8];
        case (a)
            8'h10: return status;
            8'h11: return data_rx;
            8'h12: return {2'b00, urx_full, urx_half, urx_pres, utx_full, utx_half, utx_pres};
            8'h13: return switch[7:0];
            8'h14: return switch[15:8];
            8'h15: return button;
            8'h16: return {5'b00000, m_flags};
            default: return 8'h00;
        endcase
    endfunction

    function automatic void model_write(input logic [7:0] a, input logic [7:0] d);
        if (a < NR) m_reg[int'(a)] = d;
        case (a)
            8'h10: m_cmd = d;
            8'h11: if (utx_full) m_flags[2] = 1'b1;
            8'h12: m_led[7:0] = d;
            8'h13: m_led[15:8] = d;
            8'h14: m_int_en = d[0];
            8'h15: m_flags = m_flags & ~d[2:0];
            default: ;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pb.port_id = 8'h00; pb.port_out = 8'h00;
        pb.write_strobe = 1'b0; pb.kwrite_strobe = 1'b0; pb.read_strobe = 1'b0; pb.interrupt_ack = 1'b0;
        data_rx = 8'h00; urx_full = 1'b0; urx_half = 1'b0; urx_pres = 1'b0;
        utx_full = 1'b0; utx_half = 1'b0; utx_pres = 1'b0;
        reg_in = '0; status = 8'h00; switch = 16'h0000; button = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        for (int i = 0; i < NR; i++) m_reg[i] = 8'h00;
        m_cmd = 8'h00; m_led = 16'h0000; m_int_en = 1'b1; m_flags = 3'b000;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        pb.port_id = a; pb.port_out = d; pb.write_strobe = 1'b1;
        step();
        pb.write_strobe = 1'b0;
        model_write(a, d);
    endtask

    task automatic kwr(input logic [7:0] a, input logic [7:0] d);
        pb.port_id = a; pb.port_out = d; pb.kwrite_strobe = 1'b1;
        step();
        pb.kwrite_strobe = 1'b0;
        if (int'(a[3:0]) < NR) m_reg[int'(a[3:0])] = d;
    endtask

    task automatic rd_raw(input logic [7:0] a);
        pb.port_id = a; pb.read_strobe = 1'b1;
        step();
        pb.read_strobe = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a);
        logic [7:0] e;
        logic       pop;
        e   = model_read(a);
        pop = (a == 8'h11) && urx_pres;
        rd_raw(a);
        chk(tag, pb.port_in, e);
        chk({tag, "_pop"}, urx_read, pop);
        if (a == 8'h11 && !urx_pres) m_flags[1] = 1'b1;
    endtask

    initial begin
        logic [7:0] a, d;
        int         op;

        // Reset state and free-running periodic interrupt without ack
        do_reset();
        chk("rst_port_in", pb.port_in, 0);
        chk("rst_reg_out", reg_out, 0);
        chk("rst_command", command, 0);
        chk("rst_cstb", cmd_strobe, 0);
        chk("rst_led", led, 0);
        chk("rst_int", pb.interrupt, 0);
        chk("rst_urx_read", urx_read, 0);
        pb.port_id = 8'h16;
        for (int k = 1; k <= 21; k++) begin
            step();
            chk("int_rise", pb.interrupt, cyc >= 10);
            chk("int_ovr", pb.port_in, (cyc >= 21) ? 8'h01 : 8'h00);
        end
        m_flags = 3'b001;
        pb.interrupt_ack = 1'b1;
        step();
        pb.interrupt_ack = 1'b0;
        chk("int_ack", pb.interrupt, 0);
        wr(8'h15, 8'h01);
        wr(8'h14, 8'h00);
        rd_chk("ovr_cleared", 8'h16);

        // Register map, OUTPUTK and ignored index
        for (int i = 0; i < 8; i++) wr(8'(i), 8'hA0 + 8'(i));
        kwr(8'h03, 8'h5C);
        wr(8'h08, 8'hFF);
        chk("map_regs", reg_out, 64'hA7A6_A5A4_5CA2_A1A0);
        chk("map_model", reg_out, m_pack());

        // Back-to-back command writes
        wr(8'h10, 8'h11);
        chk("cmd1_stb", cmd_strobe, 1);
        chk("cmd1", command, 8'h11);
        wr(8'h10, 8'h22);
        chk("cmd2_stb", cmd_strobe, 1);
        chk("cmd2", command, 8'h22);
        pb.port_id = 8'h00;
        step();
        chk("cmd_stb_end", cmd_strobe, 0);
        chk("cmd_hold", command, 8'h22);

        wr(8'h12, 8'h5A);
        wr(8'h13, 8'hC3);
        chk("led", led, 16'hC35A);

        // UART RX pop and underflow
        data_rx = 8'h9E; urx_pres = 1'b1;
        rd_chk("rx_pop", 8'h11);
        chk("rx_pop_val", pb.port_in, 8'h9E);
        urx_pres = 1'b0;
        pb.port_id = 8'h00;
        step();
        chk("rx_pop_end", urx_read, 0);
        rd_chk("rx_udf", 8'h11);
        rd_chk("flags_udf", 8'h16);
        chk("flags_udf_val", pb.port_in, 8'h02);

        // UART TX push while full
        utx_full = 1'b1;
        pb.port_id = 8'h11; pb.port_out = 8'h3C; pb.write_strobe = 1'b1;
        #1;
        chk("tx_write", utx_write, 1);
        chk("tx_data", data_tx, 8'h3C);
        step();
        pb.write_strobe = 1'b0;
        model_write(8'h11, 8'h3C);
        #1;
        chk("tx_write_end", utx_write, 0);
        utx_full = 1'b0;
        rd_chk("flags_ovf", 8'h16);
        chk("flags_ovf_val", pb.port_in, 8'h06);
        rd_chk("unmapped", 8'h20);

        // Randomized mix of writes, OUTPUTK writes and reads
        for (int it = 0; it < 300; it++) begin
            reg_in  = {$urandom, $urandom};
            status  = 8'($urandom);  data_rx = 8'($urandom);
            switch  = 16'($urandom); button  = 8'($urandom);
            urx_full = 1'($urandom); urx_half = 1'($urandom); urx_pres = 1'($urandom);
            utx_full = 1'($urandom); utx_half = 1'($urandom); utx_pres = 1'($urandom);
            op = $urandom_range(0, 2);
            d  = 8'($urandom);
            if (op == 0) begin
                a = 8'($urandom_range(0, 31));
                if (a == 8'h14) a = 8'h12;
                wr(a, d);
                chk("rnd_cstb", cmd_strobe, a == 8'h10);
                chk("rnd_cmd", command, m_cmd);
            end else if (op == 1) begin
                a = 8'($urandom);
                kwr(a, d);
                chk("rnd_kcstb", cmd_strobe, 0);
            end else begin
                a = 8'($urandom_range(0, 31));
`ifdef CCH_BUTTON_EVENT_EN
                if (a == 8'h17) a = 8'h16;
`endif
                rd_chk("rnd_rd", a);
            end
            chk("rnd_reg_out", reg_out, m_pack());
            chk("rnd_led", led, m_led);
            chk("rnd_int", pb.interrupt, 0);
        end

        // Button events
        urx_pres = 1'b0;
        button = 8'h00;
        step();
        step();
`ifdef CCH_BUTTON_EVENT_EN
        rd_raw(8'h17);
        button = 8'h05;
        step();
        step();
        rd_raw(8'h17);
        chk("btn_evt", pb.port_in, 8'h05);
        rd_raw(8'h17);
        chk("btn_evt_clr", pb.port_in, 8'h00);
`else
        button = 8'h05;
        step();
        rd_raw(8'h17);
        chk("btn_evt_off", pb.port_in, 8'h00);
        rd_raw(8'h17);
        chk("btn_evt_off2", pb.port_in, 8'h00);
`endif

        // Reset mid-operation, then ack/tick collision and int_en drop while pending
        reset = 1'b1;
        step();
        do_reset();
        chk("rst2_reg_out", reg_out, 0);
        chk("rst2_led", led, 0);
        chk("rst2_command", command, 0);
        chk("rst2_port_in", pb.port_in, 0);
        chk("rst2_int", pb.interrupt, 0);
        while (cyc < 10) step();
        chk("int2_rise", pb.interrupt, 1);
        while (cyc < 19) step();
        pb.interrupt_ack = 1'b1;
        step();
        pb.interrupt_ack = 1'b0;
        chk("ack_tick_hold", pb.interrupt, 1);
        pb.interrupt_ack = 1'b1;
        step();
        pb.interrupt_ack = 1'b0;
        chk("ack2", pb.interrupt, 0);
        rd_chk("ack_tick_no_ovr", 8'h16);
        while (cyc < 30) step();
        chk("int3_rise", pb.interrupt, 1);
        wr(8'h14, 8'h00);
        chk("int_en_drop", pb.interrupt, 0);
        while (cyc < 41) step();
        chk("int_disabled", pb.interrupt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
